serial_parallel_receiver_right: RTL and testbench

SERIAL_PARALLEL_RECEIVER_RIGHT -- requirements
Module: serial_parallel_receiver_right

---
 rtl/serial_parallel_receiver_right.sv | 71 +++++++
 tb/tb_serial_parallel_receiver_right.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_parallel_receiver_right.sv
// rtl/serial_parallel_receiver_right.sv - LSB-first serial-to-parallel receiver with start/clear framing
module serial_parallel_receiver_right #(
   parameter int WIDTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       clear,
   input  logic                       s_valid,
   input  logic                       s_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_valid,
   output logic                       busy,
   output logic [$clog2(WIDTH):0]     bit_cnt
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_next;

   // Next shift-register value: incoming bit enters at the MSB, so the first bit ends in bit 0.
   always_comb begin
      sh_next = {s_in, sh[WIDTH-1:1]};
   end

   // Frame FSM; clear beats start beats s_valid, and every output is a register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sh         <= '0;
         bit_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (clear) begin
            state   <= IDLE;
            busy    <= 1'b0;
            sh      <= '0;
            bit_cnt <= '0;
         end else if (start) begin
            // Also a restart when already shifting; any bit on this edge is dropped.
            state   <= SHIFT;
            busy    <= 1'b1;
            sh      <= '0;
            bit_cnt <= '0;
         end else if (state == SHIFT && s_valid) begin
            sh <= sh_next;
            if (bit_cnt == LAST_BIT) begin
               data_out   <= sh_next;
               data_valid <= 1'b1;
               bit_cnt    <= '0;
               state      <= IDLE;
               busy       <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_parallel_receiver_right.sv
// tb/tb_serial_parallel_receiver_right.sv - directed vector bench for serial_parallel_receiver_right
module tb_serial_parallel_receiver_right;

   logic       clock;
   logic       reset;
   logic       start;
   logic       clear;
   logic       s_valid;
   logic       s_in;
   logic [3:0] data_out;
   logic       data_valid;
   logic       busy;
   logic [2:0] bit_cnt;

   int n_vec;
   int n_err;

   typedef struct {
      logic       st;
      logic       cl;
      logic       sv;
      logic       si;
      logic [3:0] dout;
      logic       dv;
      logic       bz;
      logic [2:0] cnt;
      string      name;
   } vec_t;

   vec_t tbl[$];

   serial_parallel_receiver_right #(.WIDTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .clear      (clear),
      .s_valid    (s_valid),
      .s_in       (s_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .bit_cnt    (bit_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic add(input logic st, input logic cl, input logic sv, input logic si,
                      input logic [3:0] dout, input logic dv, input logic bz,
                      input logic [2:0] cnt, input string name);
      vec_t v;
      v.st = st; v.cl = cl; v.sv = sv; v.si = si;
      v.dout = dout; v.dv = dv; v.bz = bz; v.cnt = cnt; v.name = name;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] dout, input logic dv,
                        input logic bz, input logic [2:0] cnt);
      n_vec++;
      if (data_out !== dout || data_valid !== dv || busy !== bz || bit_cnt !== cnt) begin
         n_err++;
         $display("FAIL %s: got data_out=%h data_valid=%b busy=%b bit_cnt=%0d, want data_out=%h data_valid=%b busy=%b bit_cnt=%0d",
                  name, data_out, data_valid, busy, bit_cnt, dout, dv, bz, cnt);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0; start = 1'b0; clear = 1'b0; s_valid = 1'b0; s_in = 1'b0;

      //  st cl sv si  dout  dv bz cnt
      // basic word 1,1,0,1 -> B
      add(1,0,0,0, 4'h0, 0,1,3'd0, "basic_start");
      add(0,0,1,1, 4'h0, 0,1,3'd1, "basic_b0");
      add(0,0,1,1, 4'h0, 0,1,3'd2, "basic_b1");
      add(0,0,1,0, 4'h0, 0,1,3'd3, "basic_b2");
      add(0,0,1,1, 4'hB, 1,0,3'd0, "basic_done");
      add(0,0,0,0, 4'hB, 0,0,3'd0, "basic_pulse_end");
      add(0,0,1,1, 4'hB, 0,0,3'd0, "idle_ignores_bit");
      // restart: 1,0 then start, then 0,0,1,1 -> C
      add(1,0,0,0, 4'hB, 0,1,3'd0, "rs_start");
      add(0,0,1,1, 4'hB, 0,1,3'd1, "rs_b0");
      add(0,0,1,0, 4'hB, 0,1,3'd2, "rs_b1");
      add(1,0,1,1, 4'hB, 0,1,3'd0, "rs_restart");
      add(0,0,1,0, 4'hB, 0,1,3'd1, "rs_n0");
      add(0,0,1,0, 4'hB, 0,1,3'd2, "rs_n1");
      add(0,0,1,1, 4'hB, 0,1,3'd3, "rs_n2");
      add(0,0,1,1, 4'hC, 1,0,3'd0, "rs_done");
      add(0,0,0,0, 4'hC, 0,0,3'd0, "rs_pulse_end");
      // gapped 1,1,0,1 with 3 idle cycles between bits -> B
      add(1,0,0,0, 4'hC, 0,1,3'd0, "gap_start");
      add(0,0,1,1, 4'hC, 0,1,3'd1, "gap_b0");
      for (int i = 0; i < 3; i++) add(0,0,0,1, 4'hC, 0,1,3'd1, "gap_hold1");
      add(0,0,1,1, 4'hC, 0,1,3'd2, "gap_b1");
      for (int i = 0; i < 3; i++) add(0,0,0,1, 4'hC, 0,1,3'd2, "gap_hold2");
      add(0,0,1,0, 4'hC, 0,1,3'd3, "gap_b2");
      for (int i = 0; i < 3; i++) add(0,0,0,0, 4'hC, 0,1,3'd3, "gap_hold3");
      add(0,0,1,1, 4'hB, 1,0,3'd0, "gap_done");
      add(0,0,0,0, 4'hB, 0,0,3'd0, "gap_pulse_end");
      // clear after 3 bits keeps data_out
      add(1,0,0,0, 4'hB, 0,1,3'd0, "clr_start");
      add(0,0,1,1, 4'hB, 0,1,3'd1, "clr_b0");
      add(0,0,1,1, 4'hB, 0,1,3'd2, "clr_b1");
      add(0,0,1,1, 4'hB, 0,1,3'd3, "clr_b2");
      add(0,1,1,1, 4'hB, 0,0,3'd0, "clr_abort");
      add(0,0,0,0, 4'hB, 0,0,3'd0, "clr_no_pulse");
      add(1,1,1,1, 4'hB, 0,0,3'd0, "clr_beats_start");
      // back-to-back 5 (1,0,1,0) then A (0,1,0,1), start in the pulse cycle
      add(1,0,0,0, 4'hB, 0,1,3'd0, "b2b_start");
      add(0,0,1,1, 4'hB, 0,1,3'd1, "b2b_5b0");
      add(0,0,1,0, 4'hB, 0,1,3'd2, "b2b_5b1");
      add(0,0,1,1, 4'hB, 0,1,3'd3, "b2b_5b2");
      add(0,0,1,0, 4'h5, 1,0,3'd0, "b2b_5done");
      add(1,0,1,1, 4'h5, 0,1,3'd0, "b2b_start_in_pulse");
      add(0,0,1,0, 4'h5, 0,1,3'd1, "b2b_Ab0");
      add(0,0,1,1, 4'h5, 0,1,3'd2, "b2b_Ab1");
      add(0,0,1,0, 4'h5, 0,1,3'd3, "b2b_Ab2");
      add(0,0,1,1, 4'hA, 1,0,3'd0, "b2b_Adone");
      add(0,0,0,0, 4'hA, 0,0,3'd0, "b2b_pulse_end");
      // start on the final-bit cycle discards the word
      add(1,0,0,0, 4'hA, 0,1,3'd0, "fin_start");
      add(0,0,1,0, 4'hA, 0,1,3'd1, "fin_b0");
      add(0,0,1,0, 4'hA, 0,1,3'd2, "fin_b1");
      add(0,0,1,0, 4'hA, 0,1,3'd3, "fin_b2");
      add(1,0,1,0, 4'hA, 0,1,3'd0, "fin_restart");
      add(0,1,0,0, 4'hA, 0,0,3'd0, "fin_clear");

      @(negedge clock);
      @(negedge clock);
      check("reset_state", 4'h0, 1'b0, 1'b0, 3'd0);
      reset = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clock);
         start = tbl[i].st; clear = tbl[i].cl; s_valid = tbl[i].sv; s_in = tbl[i].si;
         @(posedge clock);
         #1;
         check(tbl[i].name, tbl[i].dout, tbl[i].dv, tbl[i].bz, tbl[i].cnt);
      end

      // asynchronous reset mid-frame after two bits
      @(negedge clock);
      start = 1'b1; clear = 1'b0; s_valid = 1'b0;
      @(negedge clock);
      start = 1'b0; s_valid = 1'b1; s_in = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      check("ar_two_bits", 4'hA, 1'b0, 1'b1, 3'd2);
      #2;
      reset = 1'b0;
      #1;
      check("ar_immediate", 4'h0, 1'b0, 1'b0, 3'd0);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         check("ar_no_start_ignored", 4'h0, 1'b0, 1'b0, 3'd0);
      end
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      check("ar_restart", 4'h0, 1'b0, 1'b1, 3'd0);
      @(negedge clock);
      start = 1'b0; s_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
